// File: rtl/matrix_mem_writer_if.sv
// Memory write port of the matrix writer.
// The writer drives a word address and a packed data word with a write
// request, and the memory answers with ready in the cycle it takes the word.
interface matrix_mem_writer_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ready;

    modport master (output we, output addr, output wdata, input ready);
    modport slave  (input we, input addr, input wdata, output ready);
endinterface

// File: rtl/matrix_mem_writer.sv
// Downstream stage of the matrix normalizer.
// On start it snapshots the SIZE x SIZE matrix, packs the elements row-major
// and little-endian into memory words, and writes them one per accepted
// handshake. It also reports a per-frame byte checksum and a frame count.
module matrix_mem_writer #(
    parameter int WIDTH          = 8,
    parameter int SIZE           = 10,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int BASE_ADDR      = 0
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_start,
    input  logic [0:SIZE-1][0:SIZE-1][WIDTH-1:0] i_matrix,
    matrix_mem_writer_if.master                 mem_bus,
    output logic                                o_busy,
    output logic                                o_done,
    output logic [15:0]                         o_checksum,
    output logic [7:0]                          o_frame_count
);

    localparam int NELEM  = SIZE * SIZE;
    localparam int NWORDS = (NELEM + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
    localparam int BUF_N  = NWORDS * BYTES_PER_WORD;
    localparam int BUF_W  = (BUF_N > 1) ? $clog2(BUF_N) : 1;
    localparam int IDX_W  = $clog2(NWORDS + 1);
    localparam int WORD_W = WIDTH * BYTES_PER_WORD;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NWORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t                  r_state;

    // The buffer is padded to a whole number of words; pad slots hold zero
    // so the last word's unused lanes come out as zero without extra logic.
    logic [WIDTH-1:0]        r_buf     [0:BUF_N-1];
    logic [WIDTH-1:0]        w_capElem [0:BUF_N-1];

    logic [WORD_W-1:0]       w_firstWord;
    logic [WORD_W-1:0]       w_nextWord;
    logic [IDX_W-1:0]        w_nextIdx;
    logic [BUF_W-1:0]        w_nextBase;
    logic [15:0]             w_wordSum;

    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [WORD_W-1:0]       r_wdata;
    logic [IDX_W-1:0]        r_wordIdx;
    logic [15:0]             r_sum;
    logic                    r_busy;
    logic                    r_done;
    logic [15:0]             r_checksum;
    logic [7:0]              r_frameCount;

    // Flatten the incoming matrix row-major into the padded element order.
    always_comb begin
        for (int e = 0; e < BUF_N; e++) begin
            if (e < NELEM) begin
                w_capElem[e] = i_matrix[e / SIZE][e % SIZE];
            end else begin
                w_capElem[e] = '0;
            end
        end
    end

    // Word 0 comes straight from the input so it can be presented in the cycle after start.
    always_comb begin
        w_firstWord = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            w_firstWord[l*WIDTH +: WIDTH] = w_capElem[l];
        end
    end

    // Following words are read from the captured buffer, element k*BPW in the low lane.
    always_comb begin
        w_nextIdx  = r_wordIdx + 1'b1;
        w_nextBase = BUF_W'(w_nextIdx) * BUF_W'(BYTES_PER_WORD);
        w_nextWord = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            w_nextWord[l*WIDTH +: WIDTH] = r_buf[w_nextBase + BUF_W'(l)];
        end
    end

    // Sum of the lanes of the word on the bus; pad lanes are zero so they add nothing.
    always_comb begin
        w_wordSum = '0;
        for (int l = 0; l < BYTES_PER_WORD; l++) begin
            w_wordSum = w_wordSum + 16'(r_wdata[l*WIDTH +: WIDTH]);
        end
    end

    // Snapshot the matrix on an accepted start; later input changes cannot reach the frame.
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_start) begin
            r_buf <= w_capElem;
        end
    end

    // Frame sequencer: present each word until accepted, then finish with done and the checksum.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_addr       <= BASE;
            r_wdata      <= '0;
            r_wordIdx    <= '0;
            r_sum        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_checksum   <= '0;
            r_frameCount <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_wdata   <= w_firstWord;
                        r_addr    <= BASE;
                        r_we      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_wordIdx <= '0;
                        r_sum     <= '0;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_we && mem_bus.ready) begin
                        if (r_wordIdx < LAST_IDX) begin
                            r_sum     <= r_sum + w_wordSum;
                            r_wordIdx <= w_nextIdx;
                            r_addr    <= r_addr + 1'b1;
                            r_wdata   <= w_nextWord;
                        end else begin
                            r_sum        <= r_sum + w_wordSum;
                            r_checksum   <= r_sum + w_wordSum;
                            r_frameCount <= r_frameCount + 1'b1;
                            r_we         <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_bus.we    = r_we;
    assign mem_bus.addr  = r_addr;
    assign mem_bus.wdata = r_wdata;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_checksum    = r_checksum;
    assign o_frame_count = r_frameCount;

endmodule

// File: doc/matrix_mem_writer.md
# matrix_mem_writer

Downstream stage of the matrix normalization block. On `start`, driven by the normalizer's one-cycle `done`, it captures the SIZE×SIZE 8-bit normalized matrix. It then packs the elements row-major into memory words and writes them to a single-port memory through a request/ready handshake. It also reports a per-frame byte checksum and a running frame count.

## Interface
- WIDTH, 8, element width in bits (must match normalizer WIDTH_OUT)
- SIZE, 10, matrix dimension (SIZE×SIZE elements)
- BYTES_PER_WORD, 4, elements packed per memory word
- ADDR_WIDTH, 16, memory word-address width
- BASE_ADDR, 0, word address of element [0][0]
- clk  input  1  single clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; captures matrix_in and begins a frame (honoured only in IDLE)
- matrix_in  input  WIDTH per element, [0:SIZE-1][0:SIZE-1]  unsigned normalized matrix
- mem_we  output  1  write request; data and address valid while high
- mem_addr  output  ADDR_WIDTH  word address
- mem_wdata  output  WIDTH*BYTES_PER_WORD  packed word
- mem_ready  input  1  memory accepts the current word this cycle when mem_we && mem_ready
- busy  output  1  high from the cycle after accepted start until the last word is accepted
- done  output  1  one-cycle pulse after the last word is accepted
- checksum  output  16  sum of all SIZE*SIZE elements mod 2^16 for the last completed frame
- frame_count  output  8  completed frames, wraps 255→0

## Operation
- NWORDS = ceil(SIZE*SIZE / BYTES_PER_WORD). Element index e = row*SIZE + col. Word k holds elements BYTES_PER_WORD*k … +BYTES_PER_WORD-1. Element BYTES_PER_WORD*k sits in bits [WIDTH-1:0], i.e. little-endian.
- Pad lanes past element SIZE*SIZE-1 in the last word are 0.
- Word k is written to address BASE_ADDR + k, truncated to ADDR_WIDTH.
- States: IDLE and WRITE.
- IDLE:
  - On start, copy matrix_in into an internal buffer and load word 0 into mem_wdata.
  - Set mem_addr = BASE_ADDR, mem_we = 1, busy = 1. Clear the word index and the running sum. Go to WRITE.
  - Changes to matrix_in after the start cycle have no effect on the frame.
- WRITE:
  - While mem_ready = 0, mem_we, mem_addr and mem_wdata stay stable.
  - On accept, add that word's unpadded elements to the running sum (zero-extended).
  - If k < NWORDS-1: load word k+1 and increment mem_addr.
  - Else (last word):
    - Clear mem_we and busy.
    - Pulse done for one cycle.
    - Load checksum with the final sum.
    - Increment frame_count.
    - Return to IDLE.
- start in WRITE is ignored; start in the done cycle, which is an IDLE cycle, is accepted.
- checksum and frame_count hold between frames.
- Reset values: mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, busy 0, done 0, checksum 0, frame_count 0, state IDLE. The internal buffer need not be cleared.
- Reset mid-frame aborts the frame. No further writes occur, done is not pulsed, and the counters return to 0.

## Timing
- All outputs are registered.
- start sampled high at edge 0 → mem_we high from cycle 1 with word 0.
- With mem_ready held at 1, one word is accepted per cycle. The last word is accepted at edge NWORDS, and done, checksum and frame_count are updated in cycle NWORDS+1. For SIZE=10 and BYTES_PER_WORD=4, done appears in cycle 26.
- Each cycle with mem_ready = 0 during WRITE adds exactly one cycle of latency.
- Reset asserted at an edge → mem_we is 0 in the following cycle.

## Test plan
- Reset, then idle with no start → mem_we=0, busy=0, done=0, checksum=0, frame_count=0, mem_addr=BASE_ADDR for 20 cycles.
- SIZE=10, matrix_in[r][c]=10r+c, mem_ready=1, start pulse:
  - 25 writes to addresses 0..24; word0=0x03020100, word24=0x63626160.
  - done only in cycle 26; checksum=0x1356 (4950); frame_count=1.
- Same frame with mem_ready alternating 0/1 → identical address/data sequence; values held stable across each ready=0 cycle; done in cycle 50; same checksum.
- SIZE=3, matrix_in = 0..8 row-major → 3 words: 0x03020100, 0x07060504, 0x00000008; checksum=36.
- Set matrix_in to all 0xFF in the cycle after start, and pulse start again mid-frame → output still equals the captured ramp; exactly 25 writes; one done pulse.
- After 5 accepted words, assert reset for one cycle → no further mem_we, frame_count=0. A new start restarts at BASE_ADDR with word 0 and completes normally.
